alu: RTL and testbench
======================

// Module: alu
// PURPOSE
//  Registered W-bit arithmetic/logic unit with eight functions selected by s2:s0,
//  following the 74x381 function table. Datapath primitive for small
//  accumulator/counter datapaths; the result and carry are captured on the
//  rising clock edge, giving one cycle of latency.
// PARAMETERS
//  W  4  operand/result width in bits (W >= 1)
// PORTS
//  clk    in   1  system clock, rising-edge active
//  reset  in   1  asynchronous reset, active-high
//  s0     in   1  function select bit 0
//  s1     in   1  function select bit 1
//  s2     in   1  function select bit 2
//  a      in   W  operand A (unsigned)
//  b      in   W  operand B (unsigned)
//  ci     in   1  carry in
//  z      out  W  registered result
//  co     out  1  registered carry out
// BEHAVIOUR
//  - Clock and reset: one clock (clk); reset is asynchronous and active-high.
//    While reset=1: z=0, co=0 (and zf=0, ov=0 when present), independent of clk.
//  - Latency: inputs sampled at rising clk edge N; z/co valid after edge N.
//    There is no enable; a new result is registered every cycle.
//  - Function table, op = {s2,s1,s0}; sums are computed W+1 bits wide:
//      000 CLEAR : z=0,                 co=0
//      001 B-A   : {co,z} = b + ~a + ci
//      010 A-B   : {co,z} = a + ~b + ci
//      011 A+B   : {co,z} = a + b + ci
//      100 XOR   : z=a^b,               co=0
//      101 OR    : z=a|b,               co=0
//      110 AND   : z=a&b,               co=0
//      111 PRESET: z={W{1'b1}},         co=0
//  - Subtraction: a true difference requires ci=1. With ci=1, co=1 means
//    no borrow; co=0 means a borrow occurred.
//  - Wrap-around: results are modulo 2^W; the carry leaves only through co.
//  - ci is ignored for ops 000 and 100-111.
//  - X/Z on any select bit is not required to be handled.
//  - Release of reset between edges: outputs hold 0 until the next rising edge.
//  - Fully combinational next-state logic; no state beyond the output registers.
// CONFIGURATION
//  ALU_FLAGS_EN defined: adds two registered output ports, same timing and
//  reset as z:
//    zf  out 1  1 when the next z equals 0
//    ov  out 1  two's-complement signed overflow for ops 001/010/011;
//               0 for all other ops
//  ALU_FLAGS_EN undefined: zf/ov ports and their logic are absent; the
//  port list is exactly as in PORTS.
// TESTING (W=4)
//  1 reset=1 with any inputs -> z=0, co=0; deassert reset, hold ops -> update on
//    the next edge only.
//  2 op=011, ci=0, sweep a=0..3, b=0..3 (16 vectors, a=i%4, b=i/4) ->
//    z=a+b, co=0 one cycle later (e.g. a=3,b=3 -> z=6).
//  3 op=011: a=F,b=1,ci=0 -> z=0,co=1; a=F,b=F,ci=1 -> z=F,co=1.
//  4 op=010, ci=1: a=5,b=3 -> z=2,co=1; a=3,b=5 -> z=E,co=0.
//    op=001, ci=1: a=3,b=5 -> z=2,co=1.
//  5 a=C,b=A: op=100 -> z=6; op=101 -> z=E; op=110 -> z=8;
//    op=000 -> z=0; op=111 -> z=F; co=0 for all.
//  6 ALU_FLAGS_EN: op=011, a=7,b=1,ci=0 -> z=8, ov=1, zf=0;
//    op=010, a=4,b=4,ci=1 -> z=0, zf=1, ov=0.
//    Assert reset mid-stream -> z, co, zf, ov return to 0 immediately.

Source files
------------

// File: rtl/alu.sv
// Registered W-bit ALU following the 74x381 function table.
// Optional zf/ov flag outputs are built when ALU_FLAGS_EN is defined.
module alu #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s0,
  input  logic         s1,
  input  logic         s2,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] z,
  output logic         co
`ifdef ALU_FLAGS_EN
  ,
  output logic         zf,
  output logic         ov
`endif
);

  logic [2:0]   w_op;
  logic [W-1:0] w_x;
  logic [W-1:0] w_y;
  logic         w_arith;
  logic [W:0]   w_sum;
  logic [W-1:0] w_nz;
  logic         w_nco;

  logic [W-1:0] r_z;
  logic         r_co;

  assign w_op = {s2, s1, s0};

  // Pick adder operands: subtraction inverts the subtrahend, ci supplies the +1.
  always_comb begin
    w_x     = a;
    w_y     = b;
    w_arith = 1'b0;
    case (w_op)
      3'b001: begin
        w_x     = b;
        w_y     = ~a;
        w_arith = 1'b1;
      end
      3'b010: begin
        w_y     = ~b;
        w_arith = 1'b1;
      end
      3'b011: w_arith = 1'b1;
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{W{1'b0}}, ci};

  // Next result and carry; only the arithmetic ops drive a carry out.
  always_comb begin
    w_nz  = '0;
    w_nco = w_arith ? w_sum[W] : 1'b0;
    case (w_op)
      3'b000: w_nz = '0;
      3'b001: w_nz = w_sum[W-1:0];
      3'b010: w_nz = w_sum[W-1:0];
      3'b011: w_nz = w_sum[W-1:0];
      3'b100: w_nz = a ^ b;
      3'b101: w_nz = a | b;
      3'b110: w_nz = a & b;
      3'b111: w_nz = '1;
      default: w_nz = '0;
    endcase
  end

  // Output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_z  <= '0;
      r_co <= 1'b0;
    end else begin
      r_z  <= w_nz;
      r_co <= w_nco;
    end
  end

  assign z  = r_z;
  assign co = r_co;

`ifdef ALU_FLAGS_EN
  logic w_nov;
  logic r_zf;
  logic r_ov;

  // Signed overflow: like-signed adder operands giving a differently-signed sum.
  assign w_nov = w_arith
               & (w_x[W-1] == w_y[W-1])
               & (w_sum[W-1] != w_x[W-1]);

  // Flag registers share timing and reset with z.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_zf <= 1'b0;
      r_ov <= 1'b0;
    end else begin
      r_zf <= (w_nz == '0);
      r_ov <= w_nov;
    end
  end

  assign zf = r_zf;
  assign ov = r_ov;
`endif

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu (W=4): driver queues hand-computed
// expectations, a monitor pops and compares one cycle later.
module tb_alu;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] op;
  logic [3:0] a;
  logic [3:0] b;
  logic       ci;
  logic [3:0] z;
  logic       co;
`ifdef ALU_FLAGS_EN
  logic       zf;
  logic       ov;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] z;
    logic       co;
    logic       zf;
    logic       ov;
    string      tag;
  } exp_t;

  exp_t q[$];

  alu #(.W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .s0    (op[0]),
    .s1    (op[1]),
    .s2    (op[2]),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .z     (z),
    .co    (co)
`ifdef ALU_FLAGS_EN
    ,
    .zf    (zf),
    .ov    (ov)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] iop, input logic [3:0] ia,
                       input logic [3:0] ib, input logic ici,
                       input logic [3:0] ez, input logic eco,
                       input logic ezf, input logic eov,
                       input string tag);
    exp_t e;
    @(negedge clk);
    op = iop;
    a  = ia;
    b  = ib;
    ci = ici;
    e.z = ez;
    e.co = eco;
    e.zf = ezf;
    e.ov = eov;
    e.tag = tag;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: output is presented every cycle out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!reset && q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".z"}, 32'(z), 32'(e.z));
        chk({e.tag, ".co"}, 32'(co), 32'(e.co));
`ifdef ALU_FLAGS_EN
        chk({e.tag, ".zf"}, 32'(zf), 32'(e.zf));
        chk({e.tag, ".ov"}, 32'(ov), 32'(e.ov));
`endif
      end
    end
  end

  initial begin
    reset = 1'b1;
    op = 3'($urandom_range(0, 7));
    a  = 4'($urandom_range(0, 15));
    b  = 4'($urandom_range(0, 15));
    ci = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.z", 32'(z), 0);
    chk("rst.co", 32'(co), 0);
`ifdef ALU_FLAGS_EN
    chk("rst.zf", 32'(zf), 0);
    chk("rst.ov", 32'(ov), 0);
`endif

    // Release between edges: hold 0 until next edge, then 1+2.
    @(negedge clk);
    op = 3'b011; a = 4'd1; b = 4'd2; ci = 1'b0;
    q.push_back('{z: 4'd3, co: 1'b0, zf: 1'b0, ov: 1'b0, tag: "rel"});
    reset = 1'b0;
    #1;
    chk("rel_hold.z", 32'(z), 0);
    drain();

    // A+B sweep, a=i%4, b=i/4.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] s;
      s = 4'(i % 4 + i / 4);
      drive(3'b011, 4'(i % 4), 4'(i / 4), 1'b0,
            s, 1'b0, (s == 4'd0), 1'b0, $sformatf("sweep%0d", i));
    end

    drive(3'b011, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, "add_wrap");
    drive(3'b011, 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, "add_ff1");
    drive(3'b011, 4'h8, 4'h8, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, "add_88");
    drive(3'b011, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, "add_ovf");
    drive(3'b010, 4'h5, 4'h3, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, "a_b_53");
    drive(3'b010, 4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, "a_b_35");
    drive(3'b010, 4'h4, 4'h4, 1'b1, 4'h0, 1'b1, 1'b1, 1'b0, "a_b_44");
    drive(3'b001, 4'h3, 4'h5, 1'b1, 4'h2, 1'b1, 1'b0, 1'b0, "b_a_35");
    drive(3'b100, 4'hC, 4'hA, 1'b1, 4'h6, 1'b0, 1'b0, 1'b0, "xor");
    drive(3'b101, 4'hC, 4'hA, 1'b1, 4'hE, 1'b0, 1'b0, 1'b0, "or");
    drive(3'b110, 4'hC, 4'hA, 1'b1, 4'h8, 1'b0, 1'b0, 1'b0, "and");
    drive(3'b000, 4'hC, 4'hA, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0, "clear");
    drive(3'b111, 4'hC, 4'hA, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, "preset");
    drive(3'b011, 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b0, 1'b1, "pre_rst");
    drain();

    // Mid-stream reset clears outputs without a clock edge.
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst.z", 32'(z), 0);
    chk("mid_rst.co", 32'(co), 0);
`ifdef ALU_FLAGS_EN
    chk("mid_rst.zf", 32'(zf), 0);
    chk("mid_rst.ov", 32'(ov), 0);
`endif
    @(negedge clk);
    op = 3'b111;
    reset = 1'b0;
    q.push_back('{z: 4'hF, co: 1'b0, zf: 1'b0, ov: 1'b0, tag: "post_rst"});
    #1;
    chk("post_rst_hold.z", 32'(z), 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
